// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared framebuffer constants, types and the bus word packer for the
// note-highway rectangle blitter.
//   FB_W / FB_H / FB_PIXELS : framebuffer geometry (150 x 480, 8 bpp)
//   pix_addr_t              : linear pixel number, y*FB_W + x
//   color_code_t            : the pixel codes the display understands
//   pack_fb_word()          : builds {7'b0, pixel[16:0], color[7:0]}
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_W      = 150;
  localparam int FB_H      = 480;
  localparam int FB_PIXELS = 72000;

  typedef logic [$clog2(FB_PIXELS)-1:0] pix_addr_t;

  // Any code above BLUE is shown as white by the framebuffer peripheral.
  typedef enum logic [7:0] {
    BG    = 8'd0,
    RED   = 8'd1,
    GREEN = 8'd2,
    BLUE  = 8'd3
  } color_code_t;

  function automatic logic [31:0] pack_fb_word(input pix_addr_t addr,
                                               input logic [7:0] color);
    return {7'b0, addr, color};
  endfunction

endpackage

// File: rtl/fb_raster_walker.sv
// ---------------------------------------------------------------------------
// fb_raster_walker
// Walks a clipped rectangle in raster order and produces the linear pixel
// number of the current position. The row base is kept as a running sum so
// no multiplier is needed while walking.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : latch start position (i_x, i_y) and compute y*FB_W
//   i_advance      : step to the next pixel (one completed bus write)
//   i_x, i_y       : rectangle top-left corner
//   i_xEnd, i_yEnd : exclusive clipped right/bottom bounds
//   o_addr         : current pixel number
//   o_last         : current pixel is the final one of the rectangle
// ---------------------------------------------------------------------------
module fb_raster_walker
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_advance,
  input  logic [7:0]      i_x,
  input  logic [8:0]      i_y,
  input  logic [7:0]      i_xEnd,
  input  logic [8:0]      i_yEnd,
  output pix_addr_t       o_addr,
  output logic            o_last
);

  logic [7:0]  r_curX;
  logic [8:0]  r_curY;
  pix_addr_t   r_rowBase;

  logic [16:0] w_yBase;
  logic        w_rowEnd;
  logic        w_colEnd;

  // y*150 as y*128 + y*16 + y*4 + y*2; each term is zero-extended to 17 bits.
  assign w_yBase = {1'b0, i_y, 7'b0} + {4'b0, i_y, 4'b0}
                 + {6'b0, i_y, 2'b0} + {7'b0, i_y, 1'b0};

  assign w_rowEnd = (({1'b0, r_curX} + 9'd1)  == {1'b0, i_xEnd});
  assign w_colEnd = (({1'b0, r_curY} + 10'd1) == {1'b0, i_yEnd});
  assign o_last   = w_rowEnd && w_colEnd;
  assign o_addr   = r_rowBase + {9'b0, r_curX};

  // Position registers: load at setup, then advance one pixel per accepted
  // write, wrapping to the left column and bumping the row base at row end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_curX    <= '0;
      r_curY    <= '0;
      r_rowBase <= '0;
    end else if (i_load) begin
      r_curX    <= i_x;
      r_curY    <= i_y;
      r_rowBase <= w_yBase;
    end else if (i_advance) begin
      if (w_rowEnd) begin
        r_curX    <= i_x;
        r_curY    <= r_curY + 9'd1;
        r_rowBase <= r_rowBase + 17'(FB_W);
      end else begin
        r_curX    <= r_curX + 8'd1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_blitter.sv
// ---------------------------------------------------------------------------
// fb_rect_blitter
// Avalon-MM write master that fills an axis-aligned rectangle of the
// 150x480 8-bpp note-highway framebuffer, one pixel per accepted write.
// Configuration macro: FB_BLIT_CLIP_EN
//   defined   : rectangles are clipped to the framebuffer, err is tied 0
//   undefined : rectangles reaching past the framebuffer are rejected with
//               an err pulse and no writes (done still pulses)
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   : command handshake
//   cmd_x/y/w/h/color       : rectangle origin, size and pixel code
//   avm_address             : always 0
//   avm_chipselect          : mirrors avm_write
//   avm_write               : write request
//   avm_writedata           : {7'b0, pixel number, color}
//   avm_waitrequest         : slave stall
//   busy                    : not idle
//   done                    : one-cycle pulse when a command retires
//   err                     : one-cycle pulse when a command is rejected
// ---------------------------------------------------------------------------
module fb_rect_blitter
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic [7:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_x;
  logic [8:0] r_y;
  logic [7:0] r_w;
  logic [8:0] r_h;
  logic [7:0] r_color;
  logic [7:0] r_xEnd;
  logic [8:0] r_yEnd;

  logic [8:0] w_xSum;
  logic [9:0] w_ySum;
  logic [7:0] w_xEnd;
  logic [8:0] w_yEnd;
  logic       w_empty;
  logic       w_skip;
  pix_addr_t  w_addr;
  logic       w_last;
  logic       w_accept;

  // Widened sums so the right/bottom edge never wraps before clipping.
  assign w_xSum = {1'b0, r_x} + {1'b0, r_w};
  assign w_ySum = {1'b0, r_y} + {1'b0, r_h};
  assign w_xEnd = (w_xSum > 9'(FB_W))  ? 8'(FB_W) : w_xSum[7:0];
  assign w_yEnd = (w_ySum > 10'(FB_H)) ? 9'(FB_H) : w_ySum[8:0];

  assign w_empty = (r_w == 8'd0) || (r_h == 9'd0) ||
                   (r_x >= 8'(FB_W)) || (r_y >= 9'(FB_H));

`ifdef FB_BLIT_CLIP_EN
  assign w_skip = w_empty;
  assign err    = 1'b0;
`else
  logic w_oob;
  assign w_oob  = (w_xSum > 9'(FB_W)) || (w_ySum > 10'(FB_H));
  assign w_skip = w_empty || w_oob;
  assign err    = (r_state == S_SETUP) && w_oob;
`endif

  assign w_accept = (r_state == S_WRITE) && !avm_waitrequest;

  fb_raster_walker #(
    .FB_W (FB_W)
  ) u_walker (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_load    (r_state == S_SETUP),
    .i_advance (w_accept),
    .i_x       (r_x),
    .i_y       (r_y),
    .i_xEnd    (r_xEnd),
    .i_yEnd    (r_yEnd),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  // Command FSM. Command fields are held for the whole command so the walker
  // can rewind to the left column on every row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_xEnd  <= '0;
      r_yEnd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_xEnd  <= w_xEnd;
          r_yEnd  <= w_yEnd;
          r_state <= w_skip ? S_FIN : S_WRITE;
        end
        S_WRITE: begin
          if (w_accept && w_last) begin
            r_state <= S_FIN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once;
  // write data comes from walker registers and so holds through waitrequest.
  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_FIN);
  assign avm_write      = (r_state == S_WRITE);
  assign avm_chipselect = avm_write;
  assign avm_address    = 8'd0;
  assign avm_writedata  = avm_write ? pack_fb_word(w_addr, r_color) : 32'd0;

endmodule

// File: tb/tb_fb_rect_blitter.sv
// ---------------------------------------------------------------------------
// tb_fb_rect_blitter
// Self-checking bench for fb_rect_blitter. A reference model expands each
// accepted command into the list of pixel words it must produce, and a
// negedge monitor compares bus, handshake and status outputs against it on
// every cycle. Directed cases pin the model with literal words.
// Honours FB_BLIT_CLIP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fb_rect_blitter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x = '0;
  logic [8:0]  cmd_y = '0;
  logic [7:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [7:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] expQ[$];
  bit          errExp = 1'b0;
  bit          pending = 1'b0;
  int          hsCyc = 0;
  int          doneAt = 0;
  int          lastDoneCyc = 0;
  logic [31:0] logWord[$];
  int          logCyc[$];
  int          stallSeen = 0;
  int          errSeen = 0;
  int          doneCnt = 0;
  int          wrMode = 0;
  int          stall = 0;
  bit          expBusy, expWrite, expErr, expDone;

  fb_rect_blitter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_x           (cmd_x),
    .cmd_y           (cmd_y),
    .cmd_w           (cmd_w),
    .cmd_h           (cmd_h),
    .cmd_color       (cmd_color),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  // Expand a command into the exact pixel words it must write.
  task automatic buildExp(input int x, input int y, input int w, input int h,
                          input logic [7:0] c);
    int xe, ye;
    expQ.delete();
`ifdef FB_BLIT_CLIP_EN
    errExp = 1'b0;
`else
    errExp = (x + w > FB_W) || (y + h > FB_H);
`endif
    xe = (x + w > FB_W) ? FB_W : x + w;
    ye = (y + h > FB_H) ? FB_H : y + h;
    if (!errExp)
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++)
          expQ.push_back({7'b0, 17'(yy * FB_W + xx), c});
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      pending = 1'b0;
      expQ.delete();
      checkOutput("rst.avm_write", 32'(avm_write), 0);
      checkOutput("rst.busy", 32'(busy), 0);
      checkOutput("rst.done", 32'(done), 0);
    end else begin
      expBusy  = pending && (cyc > hsCyc);
      expWrite = expBusy && (cyc >= hsCyc + 2) && (expQ.size() > 0);
      expErr   = expBusy && (cyc == hsCyc + 1) && errExp;
      expDone  = expBusy && (expQ.size() == 0) && (cyc == doneAt);
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(!expBusy));
      checkOutput("avm_write", 32'(avm_write), 32'(expWrite));
      checkOutput("avm_chipselect", 32'(avm_chipselect), 32'(expWrite));
      checkOutput("avm_address", 32'(avm_address), 0);
      checkOutput("err", 32'(err), 32'(expErr));
      checkOutput("done", 32'(done), 32'(expDone));
      if (err) errSeen++;
      if (done) doneCnt++;
      if (avm_write && expQ.size() > 0) begin
        checkOutput("avm_writedata", avm_writedata, expQ[0]);
        if (avm_writedata == 32'h0001_2B01) stallSeen++;
        if (!avm_waitrequest) begin
          logWord.push_back(avm_writedata);
          logCyc.push_back(cyc);
          void'(expQ.pop_front());
          if (expQ.size() == 0) doneAt = cyc + 1;
        end
      end
      if (done && expDone) begin
        pending = 1'b0;
        lastDoneCyc = cyc;
      end
      if (pending && cyc > hsCyc + 1000) begin
        checkOutput("cmd_timeout", 1, 0);
        pending = 1'b0;
      end
      if (cmd_valid && cmd_ready && !pending) begin
        buildExp(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h), cmd_color);
        hsCyc = cyc;
        pending = 1'b1;
        if (expQ.size() == 0) doneAt = hsCyc + 2;
      end
    end
  end

  // Slave stall generator: none, random, or a 3-cycle stall on write two.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (wrMode)
        0: avm_waitrequest = 1'b0;
        1: avm_waitrequest = ($urandom_range(0, 2) == 0);
        default: begin
          if (logWord.size() == 1 && stall < 3) begin
            avm_waitrequest = 1'b1;
            stall++;
          end else begin
            avm_waitrequest = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic sendCmd(input int x, input int y, input int w, input int h,
                         input logic [7:0] c);
    int n = 0;
    @(posedge clk);
    #1;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) checkOutput("ready_timeout", 32'(cmd_ready), 1);
    cmd_x = 8'(x);
    cmd_y = 9'(y);
    cmd_w = 8'(w);
    cmd_h = 9'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int x, input int y, input int w,
                               input int h, input logic [7:0] c);
    int n = 0;
    logWord.delete();
    logCyc.delete();
    stallSeen = 0;
    errSeen = 0;
    doneCnt = 0;
    stall = 0;
    sendCmd(x, y, w, h, c);
    while ((pending || !cmd_ready) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (pending) checkOutput("idle_timeout", 32'(pending), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int x, y, w, h;
    #3;
    checkOutput("reset.cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset.avm_write", 32'(avm_write), 0);
    checkOutput("reset.avm_chipselect", 32'(avm_chipselect), 0);
    checkOutput("reset.avm_writedata", avm_writedata, 0);
    checkOutput("reset.avm_address", 32'(avm_address), 0);
    checkOutput("reset.busy", 32'(busy), 0);
    checkOutput("reset.done", 32'(done), 0);
    checkOutput("reset.err", 32'(err), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] single pixel");
    wrMode = 0;
    applyStimulus(0, 0, 1, 1, GREEN);
    checkOutput("single.count", logWord.size(), 1);
    checkOutput("single.word", logWord[0], 32'h0000_0002);
    checkOutput("single.first_at", logCyc[0] - hsCyc, 2);

    $display("[TB] 2x2 at right edge, no stall");
    applyStimulus(148, 1, 2, 2, RED);
    checkOutput("sq.count", logWord.size(), 4);
    checkOutput("sq.w0", logWord[0], 32'h0001_2A01);
    checkOutput("sq.w1", logWord[1], 32'h0001_2B01);
    checkOutput("sq.w2", logWord[2], 32'h0001_C001);
    checkOutput("sq.w3", logWord[3], 32'h0001_C101);
    for (int i = 0; i < 4; i++)
      checkOutput("sq.cycle", logCyc[i] - hsCyc, 2 + i);

    $display("[TB] 2x2 with 3-cycle stall on second write");
    wrMode = 2;
    applyStimulus(148, 1, 2, 2, RED);
    checkOutput("stall.count", logWord.size(), 4);
    checkOutput("stall.w1", logWord[1], 32'h0001_2B01);
    checkOutput("stall.w2", logWord[2], 32'h0001_C001);
    checkOutput("stall.held", stallSeen, 4);
    wrMode = 0;

    $display("[TB] bottom-right corner overhang");
    applyStimulus(149, 479, 4, 4, BLUE);
`ifdef FB_BLIT_CLIP_EN
    checkOutput("corner.count", logWord.size(), 1);
    checkOutput("corner.word", logWord[0], 32'h0119_3F03);
    checkOutput("corner.err", errSeen, 0);
`else
    checkOutput("corner.count", logWord.size(), 0);
    checkOutput("corner.err", errSeen, 1);
    checkOutput("corner.done", doneCnt, 1);
`endif

    $display("[TB] degenerate commands");
    applyStimulus(5, 5, 0, 3, 8'h09);
    checkOutput("w0.count", logWord.size(), 0);
    checkOutput("w0.done_at", lastDoneCyc - hsCyc, 2);
    applyStimulus(150, 0, 2, 2, 8'h09);
    checkOutput("x150.count", logWord.size(), 0);
    checkOutput("x150.done_at", lastDoneCyc - hsCyc, 2);

    $display("[TB] reset during a 10x10 fill");
    logWord.delete();
    logCyc.delete();
    doneCnt = 0;
    sendCmd(0, 0, 10, 10, 8'h07);
    n = 0;
    while (logWord.size() < 21 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rst.row2_reached", 32'(logWord.size() >= 21), 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst.write_now", 32'(avm_write), 0);
    checkOutput("rst.busy_now", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst.no_done", doneCnt, 0);
    applyStimulus(3, 2, 3, 2, RED);
    checkOutput("after_rst.count", logWord.size(), 6);
    checkOutput("after_rst.w0", logWord[0], 32'h0001_2F01);

    $display("[TB] randomized commands");
    for (int i = 0; i < 40; i++) begin
      wrMode = $urandom_range(0, 1);
      x = $urandom_range(0, 159);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 511)
                                      : $urandom_range(0, 479);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 5);
      applyStimulus(x, y, w, h, 8'($urandom_range(0, 255)));
    end
    wrMode = 0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
